// File: rtl/data_unpro.sv
// Product decoder: restoring divider (one quotient bit per clock) that recovers
// the original operand pair from a captured product and the incremented divisor.
module data_unpro #(
    parameter int WD = 8,
    parameter int WS = 4
) (
    input  logic          clk,
    input  logic          res,
    input  logic [WD-1:0] data_in,
    input  logic [WS-1:0] data_in_div,
    input  logic          en_data_in,
    output logic          busy,
    output logic [WD-1:0] quot,
    output logic [WS-1:0] rem,
    output logic [WS-1:0] data_out_a,
    output logic [WS-1:0] data_out_b,
    output logic          err_div0,
    output logic          err_inexact,
    output logic          err_range,
    output logic          en_data_out
);

    localparam int CW = $clog2(WD);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [WD-1:0] dvd;
    logic [WS-1:0] div_r;
    logic [WS:0]   prem;
    logic [CW-1:0] cnt;

    logic          start;
    logic          last;
    logic          div0;
    logic          qbit;
    logic [WS+1:0] prem_sh;
    logic [WS+1:0] trial;
    logic [WS:0]   prem_nx;
    logic [WD-1:0] dvd_nx;
    logic [WD-1:0] quot_f;

    assign busy        = (state == CALC);
    assign en_data_out = (state == DONE);

    always_comb begin
        state_nx = state;
        start    = (state != CALC) && en_data_in;
        last     = (cnt == CW'(WD - 1));
        div0     = (div_r == '0);
        // Quotient bits shift into the vacated LSBs of the dividend register
        prem_sh  = {prem, dvd[WD-1]};
        trial    = prem_sh - {2'b00, div_r};
        qbit     = ~trial[WS+1];
        prem_nx  = qbit ? trial[WS:0] : prem_sh[WS:0];
        dvd_nx   = {dvd[WD-2:0], qbit};
        quot_f   = div0 ? '1 : dvd_nx;
        case (state)
            IDLE:    if (en_data_in) state_nx = CALC;
            CALC:    if (last) state_nx = DONE;
            DONE:    state_nx = en_data_in ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state       <= IDLE;
            dvd         <= '0;
            div_r       <= '0;
            prem        <= '0;
            cnt         <= '0;
            quot        <= '0;
            rem         <= '0;
            data_out_a  <= '0;
            data_out_b  <= '0;
            err_div0    <= 1'b0;
            err_inexact <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                dvd   <= data_in;
                div_r <= data_in_div;
                prem  <= '0;
                cnt   <= '0;
            end else if (state == CALC) begin
                dvd  <= dvd_nx;
                prem <= prem_nx;
                cnt  <= cnt + 1'b1;
                if (last) begin
                    quot        <= quot_f;
                    rem         <= div0 ? '0 : prem_nx[WS-1:0];
                    data_out_a  <= div_r - 1'b1;
                    data_out_b  <= quot_f[WS-1:0] - 1'b1;
                    err_div0    <= div0;
                    err_inexact <= ~div0 && (prem_nx[WS-1:0] != '0);
                    err_range   <= |quot_f[WD-1:WS];
                end
            end
        end
    end

endmodule
